// File: rtl/riot_pia_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riot_pia_pkg
// Desc    : Register map and timer interval encoding for the RIOT block.
// Rev     : 1.0  initial release
// ============================================================================
package riot_pia_pkg;

    localparam logic [6:0] SWCHA    = 7'h00;
    localparam logic [6:0] SWACNT   = 7'h01;
    localparam logic [6:0] SWCHB    = 7'h02;
    localparam logic [6:0] SWBCNT   = 7'h03;
    localparam logic [6:0] INTIM    = 7'h04;
    localparam logic [6:0] INSTAT   = 7'h05;
    localparam logic [6:0] EDGE_CTL = 7'h04;
    localparam logic [6:0] TIM1T    = 7'h14;
    localparam logic [6:0] TIM8T    = 7'h15;
    localparam logic [6:0] TIM64T   = 7'h16;
    localparam logic [6:0] T1024T   = 7'h17;

    localparam int TIMER_IE_BIT = 3;
    localparam int LIMIT_W      = 10;

    // Prescaler terminal count for the interval selected by adr[1:0].
    function automatic logic [LIMIT_W-1:0] interval_limit(input logic [1:0] sel);
        logic [LIMIT_W-1:0] lim;
        case (sel)
            2'b00:   lim = 10'd0;
            2'b01:   lim = 10'd7;
            2'b10:   lim = 10'd63;
            default: lim = 10'd1023;
        endcase
        return lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riot_pia_if.sv
`default_nettype none
// ============================================================================
// Module  : riot_pia_if
// Desc    : CPU strobe bus between the 6507 core and the RIOT.
// Rev     : 1.0  initial release
// ============================================================================
interface riot_pia_if #(
    parameter int DATA_W = 8
) ();
    logic              stb_i;
    logic              we_i;
    logic [6:0]        adr_i;
    logic [DATA_W-1:0] dat_i;
    logic [DATA_W-1:0] dat_o;

    modport master (output stb_i, output we_i, output adr_i, output dat_i, input  dat_o);
    modport slave  (input  stb_i, input  we_i, input  adr_i, input  dat_i, output dat_o);
endinterface
`default_nettype wire

// File: rtl/riot_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : riot_edge_sync
// Desc    : Multi-stage pin synchroniser with a polarity-selectable edge
//           pulse on the synchronised MSB.
// Rev     : 1.0  initial release
// ============================================================================
module riot_edge_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic [DATA_W-1:0] pin_i,
    input  wire logic              pos_i,
    output logic      [DATA_W-1:0] sync_o,
    output logic                   edge_o
);
    logic [DATA_W-1:0] r_stage [SYNC_STAGES];
    logic              r_msb_prev;
    logic              w_msb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
            r_msb_prev <= 1'b0;
        end else begin
            r_stage[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_msb_prev <= w_msb;
        end
    end

    assign sync_o = r_stage[SYNC_STAGES-1];
    assign w_msb  = sync_o[DATA_W-1];
    assign edge_o = pos_i ? (~r_msb_prev & w_msb) : (r_msb_prev & ~w_msb);

endmodule
`default_nettype wire

// File: rtl/riot_pia.sv
`default_nettype none
// ============================================================================
// Module  : riot_pia
// Desc    : 6532-style RIOT: two DDR ports, prescaled interval timer with
//           1T-after-underflow, PA MSB edge detect and active-low IRQ.
// Rev     : 1.0  initial release
// ============================================================================
module riot_pia
    import riot_pia_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PRESC_W     = 10
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              enable_i,
    riot_pia_if.slave              bus,
    input  wire logic [DATA_W-1:0] pa_i,
    input  wire logic [DATA_W-1:0] pb_i,
    output logic      [DATA_W-1:0] pa_o,
    output logic      [DATA_W-1:0] pb_o,
    output logic      [DATA_W-1:0] pa_oe,
    output logic      [DATA_W-1:0] pb_oe,
    output logic                   irq_no,
    output logic      [DATA_W-1:0] diag
);
    localparam logic [6:0] c_IE_ADR = 7'(1 << TIMER_IE_BIT);

    logic [DATA_W-1:0]  r_dat_o, r_pa_o, r_pb_o, r_ddra, r_ddrb, r_intim;
    logic [PRESC_W-1:0] r_presc, r_interval;
    logic               r_underflow, r_timer_flag, r_edge_flag;
    logic               r_timer_ie, r_edge_ie, r_edge_pos, r_irq_n;

    logic [DATA_W-1:0]  w_pa_sync, w_pb_sync, w_pa_view, w_pb_view, w_rd_data;
    logic               w_pa_edge, w_pb_edge_unused;
    logic [6:0]         w_adr;
    logic               w_rd, w_wr, w_rd_intim, w_rd_instat, w_wr_edge, w_wr_timer;
    logic [PRESC_W-1:0] w_limit;
    logic               w_wrap;

    riot_edge_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pin_i  (pa_i),
        .pos_i  (r_edge_pos),
        .sync_o (w_pa_sync),
        .edge_o (w_pa_edge)
    );

    riot_edge_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pin_i  (pb_i),
        .pos_i  (1'b0),
        .sync_o (w_pb_sync),
        .edge_o (w_pb_edge_unused)
    );

    assign w_adr       = bus.adr_i;
    assign w_rd        = bus.stb_i & ~bus.we_i;
    assign w_wr        = bus.stb_i &  bus.we_i;
    assign w_rd_intim  = w_rd && ((w_adr == INTIM)  || (w_adr == (INTIM  | c_IE_ADR)));
    assign w_rd_instat = w_rd && ((w_adr == INSTAT) || (w_adr == (INSTAT | c_IE_ADR)));
    assign w_wr_edge   = w_wr && (w_adr[6:2] == EDGE_CTL[6:2]);
    // 0x14..0x17 and 0x1C..0x1F: adr[3] is the timer IE bit, don't-care here
    assign w_wr_timer  = w_wr && (w_adr[6:4] == TIM1T[6:4]) && w_adr[2];

    assign w_pa_view = (r_ddra & r_pa_o) | (~r_ddra & w_pa_sync);
    assign w_pb_view = (r_ddrb & r_pb_o) | (~r_ddrb & w_pb_sync);

    always_comb begin
        w_rd_data = '0;
        case (w_adr)
            SWCHA:                         w_rd_data = w_pa_view;
            SWACNT:                        w_rd_data = r_ddra;
            SWCHB:                         w_rd_data = w_pb_view;
            SWBCNT:                        w_rd_data = r_ddrb;
            INTIM,  (INTIM  | c_IE_ADR):   w_rd_data = r_intim;
            INSTAT, (INSTAT | c_IE_ADR):   w_rd_data = {r_timer_flag, r_edge_flag, {(DATA_W-2){1'b0}}};
            default:                       w_rd_data = '0;
        endcase
    end

    // After underflow the prescaler is bypassed until the next load.
    assign w_limit = r_underflow ? '0 : r_interval;
    assign w_wrap  = (r_presc == w_limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dat_o      <= '0;
            r_pa_o       <= '0;
            r_pb_o       <= '0;
            r_ddra       <= '0;
            r_ddrb       <= '0;
            r_intim      <= '0;
            r_presc      <= '0;
            r_interval   <= '0;
            r_underflow  <= 1'b0;
            r_timer_flag <= 1'b0;
            r_edge_flag  <= 1'b0;
            r_timer_ie   <= 1'b0;
            r_edge_ie    <= 1'b0;
            r_edge_pos   <= 1'b0;
            r_irq_n      <= 1'b1;
        end else begin
            if (w_rd) begin
                r_dat_o <= w_rd_data;
            end

            if (w_wr) begin
                case (w_adr)
                    SWCHA:   r_pa_o <= bus.dat_i;
                    SWACNT:  r_ddra <= bus.dat_i;
                    SWCHB:   r_pb_o <= bus.dat_i;
                    SWBCNT:  r_ddrb <= bus.dat_i;
                    default: ;
                endcase
            end

            if (w_wr_edge) begin
                r_edge_pos <= w_adr[0];
                r_edge_ie  <= w_adr[1];
            end

            if (w_wr_timer) begin
                r_intim     <= bus.dat_i;
                r_presc     <= '0;
                r_underflow <= 1'b0;
                r_interval  <= PRESC_W'(interval_limit(w_adr[1:0]));
            end else if (enable_i) begin
                if (w_wrap) begin
                    r_intim <= r_intim - 1'b1;
                    r_presc <= '0;
                    if (r_intim == '0) begin
                        r_underflow <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (w_wr_timer || w_rd_intim) begin
                r_timer_ie <= w_adr[TIMER_IE_BIT];
            end

            // Load beats underflow; a new event beats a clearing read.
            if (w_wr_timer) begin
                r_timer_flag <= 1'b0;
            end else if (enable_i && w_wrap && (r_intim == '0)) begin
                r_timer_flag <= 1'b1;
            end else if (w_rd_intim) begin
                r_timer_flag <= 1'b0;
            end

            if (w_pa_edge) begin
                r_edge_flag <= 1'b1;
            end else if (w_rd_instat) begin
                r_edge_flag <= 1'b0;
            end

            r_irq_n <= ~((r_timer_flag & r_timer_ie) | (r_edge_flag & r_edge_ie));
        end
    end

    assign bus.dat_o = r_dat_o;
    assign pa_o      = r_pa_o;
    assign pb_o      = r_pb_o;
    assign pa_oe     = r_ddra;
    assign pb_oe     = r_ddrb;
    assign irq_no    = r_irq_n;
    assign diag      = r_intim;

endmodule
`default_nettype wire

// File: tb/tb_riot_pia.sv
`default_nettype none
// ============================================================================
// Module  : tb_riot_pia
// Desc    : Scoreboard bench for riot_pia with a behavioural reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_riot_pia;
    import riot_pia_pkg::*;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] pa_in = '0, pb_in = '0;
    logic [DW-1:0] pa_o, pb_o, pa_oe, pb_oe, diag;
    logic          irq_no;

    riot_pia_if #(.DATA_W(DW)) bus ();

    riot_pia #(.DATA_W(DW), .SYNC_STAGES(SS), .PRESC_W(10)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (en),
        .bus      (bus),
        .pa_i     (pa_in),
        .pb_i     (pb_in),
        .pa_o     (pa_o),
        .pb_o     (pb_o),
        .pa_oe    (pa_oe),
        .pb_oe    (pb_oe),
        .irq_no   (irq_no),
        .diag     (diag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_pa_o, m_pb_o, m_ddra, m_ddrb, m_intim;
    int         m_period, m_elapsed;
    bit         m_1t, m_tflag, m_eflag, m_tie, m_eie, m_epos, m_irq, m_prev;
    logic [7:0] pa_hist[$], pb_hist[$];
    logic [7:0] exp_q[$];
    int         periods [4] = '{1, 8, 64, 1024};

    bit         nx_rst = 1'b0, nx_en = 1'b0;
    logic [7:0] nx_pa = '0, nx_pb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pa_o = 0; m_pb_o = 0; m_ddra = 0; m_ddrb = 0; m_intim = 0;
        m_period = 1; m_elapsed = 0; m_1t = 0;
        m_tflag = 0; m_eflag = 0; m_tie = 0; m_eie = 0; m_epos = 0;
        m_irq = 1; m_prev = 0;
        pa_hist.delete(); pb_hist.delete();
        for (int i = 0; i < SS; i++) begin
            pa_hist.push_back(8'h00);
            pb_hist.push_back(8'h00);
        end
    endfunction

    // Effect of one clock edge given the inputs presented for it.
    task automatic model_step(input bit s, input bit w, input logic [6:0] a, input logic [7:0] d);
        logic [7:0] sa, sb, rv;
        bit cur, edge_seen, rd, wr, load, rd_tim, rd_st, unf;
        sa = pa_hist[0];
        sb = pb_hist[0];
        cur = sa[7];
        edge_seen = m_epos ? (!m_prev && cur) : (m_prev && !cur);
        rd = s && !w;
        wr = s && w;
        load   = wr && (a inside {[7'h14:7'h17], [7'h1C:7'h1F]});
        rd_tim = rd && (a == 7'h04 || a == 7'h0C);
        rd_st  = rd && (a == 7'h05 || a == 7'h0D);
        unf = 0;
        if (rd) begin
            case (a)
                7'h00:        rv = (m_ddra & m_pa_o) | (~m_ddra & sa);
                7'h01:        rv = m_ddra;
                7'h02:        rv = (m_ddrb & m_pb_o) | (~m_ddrb & sb);
                7'h03:        rv = m_ddrb;
                7'h04, 7'h0C: rv = m_intim;
                7'h05, 7'h0D: rv = {m_tflag, m_eflag, 6'b0};
                default:      rv = 8'h00;
            endcase
            exp_q.push_back(rv);
        end
        m_irq = !((m_tflag && m_tie) || (m_eflag && m_eie));
        if (load) begin
            m_intim = d; m_elapsed = 0; m_1t = 0; m_period = periods[a[1:0]];
        end else if (en) begin
            m_elapsed++;
            if (m_elapsed >= (m_1t ? 1 : m_period)) begin
                m_elapsed = 0;
                if (m_intim == 0) begin
                    unf = 1;
                    m_1t = 1;
                end
                m_intim = m_intim - 8'd1;
            end
        end
        if (load || rd_tim) m_tie = a[3];
        if (load) m_tflag = 0;
        else if (unf) m_tflag = 1;
        else if (rd_tim) m_tflag = 0;
        if (edge_seen) m_eflag = 1;
        else if (rd_st) m_eflag = 0;
        if (wr) begin
            case (a)
                7'h00: m_pa_o = d;
                7'h01: m_ddra = d;
                7'h02: m_pb_o = d;
                7'h03: m_ddrb = d;
                default: ;
            endcase
            if (a inside {[7'h04:7'h07]}) begin
                m_epos = a[0];
                m_eie  = a[1];
            end
        end
        m_prev = cur;
        pa_hist.push_back(pa_in); void'(pa_hist.pop_front());
        pb_hist.push_back(pb_in); void'(pb_hist.pop_front());
    endtask

    task automatic cyc(input bit s, input bit w, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_n = nx_rst; en = nx_en; pa_in = nx_pa; pb_in = nx_pb;
        bus.stb_i = s; bus.we_i = w; bus.adr_i = a; bus.dat_i = d;
        if (nx_rst) model_step(s, w, a, d);
        else model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 7'h00, 8'h00);
    endtask
    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask
    task automatic rd(input logic [6:0] a);
        cyc(1'b1, 1'b0, a, 8'h00);
    endtask

    // Monitor: read data is scoreboarded, other outputs follow the model.
    always begin
        logic rdv;
        @(posedge clk);
        rdv = rst_n && bus.stb_i && !bus.we_i;
        #1;
        if (rdv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dat_o_unexpected actual=%0h required=none", bus.dat_o);
            end else begin
                check("dat_o", bus.dat_o, exp_q.pop_front());
            end
        end
        check("diag", diag, m_intim);
        check("irq_no", irq_no, m_irq);
        check("pa_o", pa_o, m_pa_o);
        check("pa_oe", pa_oe, m_ddra);
        check("pb_o", pb_o, m_pb_o);
        check("pb_oe", pb_oe, m_ddrb);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [6:0] adr_tab [22] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h0C, 7'h0D,
                                 7'h06, 7'h07, 7'h14, 7'h15, 7'h16, 7'h17, 7'h1C, 7'h1D,
                                 7'h1E, 7'h1F, 7'h08, 7'h7F, 7'h24, 7'h10};

    initial begin
        bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;
        model_reset();
        idle(3);
        nx_rst = 1'b1;
        idle(2);

        // Ports and DDRs
        wr(SWACNT, 8'hF0); wr(SWCHA, 8'hA5); nx_pa = 8'h3C; idle(3);
        rd(SWCHA);
        @(posedge clk); #1;
        check("port_a_read", bus.dat_o, 8'hAC);
        check("pa_o_val", pa_o, 8'hA5);
        check("pa_oe_val", pa_oe, 8'hF0);
        wr(SWBCNT, 8'h0F); wr(SWCHB, 8'h5A); nx_pb = 8'hC3; idle(3);
        rd(SWCHB);
        @(posedge clk); #1;
        check("port_b_read", bus.dat_o, 8'hCA);

        // TIM8T with IE, enable every cycle
        nx_en = 1'b1;
        wr(7'h1D, 8'h03); idle(8);
        @(posedge clk); #1; check("tim8_after8", diag, 8'h02);
        idle(24);
        @(posedge clk); #1; check("tim8_underflow", diag, 8'hFF);
        idle(1);
        @(posedge clk); #1; check("tim8_irq_low", irq_no, 1'b0); check("tim8_1t", diag, 8'hFE);
        rd(7'h0C); idle(1);
        @(posedge clk); #1; check("tim8_irq_clr", irq_no, 1'b1);

        // Gated enable: one tick per 4 clocks
        wr(7'h1D, 8'h03);
        for (int i = 1; i <= 32; i++) begin
            nx_en = (i % 4 == 0);
            idle(1);
        end
        @(posedge clk); #1; check("gated_32clk", diag, 8'h02);
        for (int i = 0; i < 100; i++) begin
            nx_en = (i % 4 == 0);
            idle(1);
        end

        // T1024T
        nx_en = 1'b1;
        wr(7'h1F, 8'h01); idle(2047);
        @(posedge clk); #1; check("t1024_at_zero", diag, 8'h00);
        idle(1);
        @(posedge clk); #1; check("t1024_underflow", diag, 8'hFF);
        idle(1);
        @(posedge clk); #1; check("t1024_irq", irq_no, 1'b0);
        rd(7'h0D); rd(INTIM); idle(2);

        // Edge detect
        nx_en = 1'b0;
        wr(TIM64T, 8'hFF); nx_pa = 8'h00; idle(4);
        wr(7'h07, 8'h00); rd(INSTAT); idle(1);
        nx_pa = 8'h80; idle(SS + 1);
        @(posedge clk); #1; check("edge_irq_pre", irq_no, 1'b1);
        idle(1);
        @(posedge clk); #1; check("edge_irq", irq_no, 1'b0);
        rd(INSTAT);
        @(posedge clk); #1; check("instat_edge", bus.dat_o, 8'h40);
        idle(1);
        @(posedge clk); #1; check("edge_irq_clr", irq_no, 1'b1);
        nx_pa = 8'h00; idle(5); rd(INSTAT);
        @(posedge clk); #1; check("no_fall_edge", bus.dat_o, 8'h00);

        // Timer load on the underflow tick
        nx_en = 1'b1;
        wr(TIM1T, 8'h02); idle(2); wr(TIM1T, 8'h55);
        @(posedge clk); #1; check("load_wins", diag, 8'h55);
        rd(INSTAT);
        @(posedge clk); #1; check("load_clr_flag", bus.dat_o, 8'h00);
        nx_en = 1'b0;

        // Edge on the same cycle as the INSTAT read
        nx_pa = 8'h80; idle(SS); rd(INSTAT); rd(INSTAT);
        @(posedge clk); #1; check("edge_set_wins", bus.dat_o, 8'h40);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [6:0] a;
            nx_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) nx_pa = 8'($urandom);
            if ($urandom_range(0, 7) == 0) nx_pb = 8'($urandom);
            r = $urandom_range(0, 9);
            a = adr_tab[$urandom_range(0, 21)];
            if (r < 4) idle(1);
            else if (r < 7) rd(a);
            else wr(a, (r == 9) ? 8'($urandom_range(0, 7)) : 8'($urandom));
        end

        // Asynchronous reset in the middle of a count
        nx_en = 1'b1; nx_pa = 8'h00;
        wr(SWACNT, 8'hFF); wr(7'h1C, 8'h80); idle(10);
        @(posedge clk); #3;
        nx_rst = 1'b0; rst_n = 1'b0; bus.stb_i = 1'b0;
        #1;
        check("rst_diag", diag, 8'h00);
        check("rst_irq", irq_no, 1'b1);
        check("rst_pa_oe", pa_oe, 8'h00);
        check("rst_pa_o", pa_o, 8'h00);
        check("rst_dat_o", bus.dat_o, 8'h00);
        model_reset();
        exp_q.delete();
        idle(2);
        nx_rst = 1'b1;
        idle(5); rd(INTIM); rd(INSTAT); idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
